// File: rtl/rv_run_ctrl.sv
// Run controller for a SoC under test: holds the SoC in reset, runs it, and
// ends the run on ebreak (pass), UART inactivity (timeout) or abort.
module rv_run_ctrl #(
    parameter int unsigned RESET_HOLD     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 32'd10_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        ebreak,
    input  logic        uart_tx,
    output logic        soc_rst_n,
    output logic        busy,
    output logic        done,
    output logic [1:0]  result,
    output logic [31:0] cycle_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RESET = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] R_PASS    = 2'b01;
    localparam logic [1:0] R_TIMEOUT = 2'b10;
    localparam logic [1:0] R_ABORT   = 2'b11;

    localparam logic [15:0] HOLD_LAST = 16'(RESET_HOLD - 1);
    localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_reg, state_next;
    logic [1:0]  result_reg, result_next;
    logic [15:0] hold_reg;
    logic [31:0] idle_reg;
    logic [31:0] count_reg;
    logic        prev_tx_reg;
    logic        done_reg;
    logic        enter_reset;
    logic        enter_run;

    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) state_next = S_RESET;
            end
            S_RESET: begin
                if (abort) begin
                    state_next  = S_DONE;
                    result_next = R_ABORT;
                end else if (hold_reg == HOLD_LAST) begin
                    state_next = S_RUN;
                end
            end
            default: begin
                // ebreak beats abort beats timeout when they coincide
                if (ebreak) begin
                    state_next  = S_DONE;
                    result_next = R_PASS;
                end else if (abort) begin
                    state_next  = S_DONE;
                    result_next = R_ABORT;
                end else if (idle_reg == IDLE_LAST) begin
                    state_next  = S_DONE;
                    result_next = R_TIMEOUT;
                end
            end
        endcase
    end

    assign enter_reset = (state_next == S_RESET) && (state_reg != S_RESET);
    assign enter_run   = (state_next == S_RUN) && (state_reg == S_RESET);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            result_reg  <= 2'b00;
            hold_reg    <= 16'd0;
            idle_reg    <= 32'd0;
            count_reg   <= 32'd0;
            prev_tx_reg <= 1'b1;
            done_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_next == S_DONE) && (state_reg != S_DONE);
            if (enter_reset) begin
                result_reg  <= 2'b00;
                count_reg   <= 32'd0;
                hold_reg    <= 16'd0;
                prev_tx_reg <= 1'b1;
            end else begin
                result_reg <= result_next;
                if (state_reg == S_RESET) begin
                    hold_reg <= hold_reg + 16'd1;
                end
                if (enter_run) begin
                    idle_reg <= 32'd0;
                end
                if (state_reg == S_RUN) begin
                    if (count_reg != 32'hFFFF_FFFF) begin
                        count_reg <= count_reg + 32'd1;
                    end
                    prev_tx_reg <= uart_tx;
                    // a falling edge on the UART line counts as activity
                    if (prev_tx_reg && !uart_tx) begin
                        idle_reg <= 32'd0;
                    end else begin
                        idle_reg <= idle_reg + 32'd1;
                    end
                end
            end
        end
    end

    assign soc_rst_n   = (state_reg == S_RUN) || (state_reg == S_DONE);
    assign busy        = (state_reg == S_RESET) || (state_reg == S_RUN);
    assign done        = done_reg;
    assign result      = result_reg;
    assign cycle_count = count_reg;

endmodule

// File: doc/rv_run_ctrl.md
RV_RUN_CTRL -- requirements
Module: rv_run_ctrl

Interface
REQ-001 SHALL have parameter RESET_HOLD, default 16: SoC reset hold length in clk cycles, range 1 to 65535.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 10_000_000: watchdog idle limit in RUN cycles, range 2 to 2^32-1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request a run, sampled each cycle.
REQ-006 SHALL have port abort, input, 1 bit: terminate the current run.
REQ-007 SHALL have port ebreak, input, 1 bit: SoC halt indication, synchronous to clk.
REQ-008 SHALL have port uart_tx, input, 1 bit: SoC serial output, monitored for activity only.
REQ-009 SHALL have port soc_rst_n, output, 1 bit: active-low reset to the SoC.
REQ-010 SHALL have port busy, output, 1 bit: high in RESET or RUN.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse on entry to DONE.
REQ-012 SHALL have port result, output, 2 bits: 00 none, 01 pass, 10 timeout, 11 abort.
REQ-013 SHALL have port cycle_count, output, 32 bits: count of RUN cycles in the last or current run.

Function
REQ-014 SHALL implement states IDLE, RESET, RUN and DONE.
REQ-015 SHALL go IDLE or DONE -> RESET on the cycle after start is sampled high; in RESET or RUN, start SHALL be ignored.
REQ-016 On RESET entry SHALL clear result to 00, cycle_count to 0 and the hold counter.
REQ-017 SHALL drive soc_rst_n low for exactly RESET_HOLD cycles in RESET, then go RESET -> RUN.
REQ-018 SHALL drive soc_rst_n high in RUN and DONE, and low in IDLE and RESET.
REQ-019 SHALL increment cycle_count by 1 every RUN cycle, saturating at 32'hFFFF_FFFF, and hold it in DONE.
REQ-020 SHALL keep a 32-bit idle counter, cleared on RUN entry and in any RUN cycle where uart_tx is 0 and the previous sample was 1, and incremented in every other RUN cycle.
REQ-021 The uart_tx previous-sample register SHALL reset to 1 and SHALL be reloaded with 1 on RESET entry.
REQ-022 RUN -> DONE with result 01 SHALL occur on the cycle after ebreak is sampled high in RUN.
REQ-023 RUN -> DONE with result 10 SHALL occur when the idle counter equals TIMEOUT_CYCLES-1 and ebreak is low, so that TIMEOUT_CYCLES RUN cycles without activity end the run.
REQ-024 RUN -> DONE with result 11 SHALL occur on the cycle after abort is sampled high in RUN or RESET; abort SHALL be ignored in IDLE and DONE.
REQ-025 Simultaneous events SHALL be prioritised ebreak > abort > timeout; only the winning result is recorded.
REQ-026 ebreak and uart_tx SHALL be ignored outside RUN.
REQ-027 done SHALL be high only in the first DONE cycle; result SHALL hold until the next RESET entry.
REQ-028 start and abort sampled together in RUN SHALL act as abort only, with no restart.

Reset
REQ-029 rst high SHALL force immediately, without waiting for clk: state IDLE, soc_rst_n 0, busy 0, done 0, result 00, cycle_count 0, idle counter 0, hold counter 0.
REQ-030 rst asserted in RESET or RUN SHALL abandon the run with no done pulse; after release the block SHALL stay in IDLE until start.

Verification (RESET_HOLD=4, TIMEOUT_CYCLES=100)
REQ-031 Bench SHALL cover: start pulse, then ebreak on the 50th RUN cycle -> soc_rst_n low for 4 cycles; done pulse; result 01; cycle_count 50.
REQ-032 Bench SHALL cover: start with uart_tx held 1 and ebreak 0 -> done after 100 RUN cycles; result 10; cycle_count 100.
REQ-033 Bench SHALL cover: start, then a uart_tx 1->0 edge at RUN cycle 90 -> timeout at RUN cycle 190; cycle_count 190.
REQ-034 Bench SHALL cover: ebreak and abort high in the same RUN cycle -> result 01; abort alone in RESET -> result 11; cycle_count 0.
REQ-035 Bench SHALL cover: rst pulse mid-RUN -> soc_rst_n 0 and all outputs at reset values asynchronously, with no done pulse.
REQ-036 Bench SHALL cover: start in DONE after a pass -> result 00 and cycle_count 0 on RESET entry, and a second full run completes.
